// File: rtl/seq_alu_exec.sv
// Multi-cycle execute unit: single-cycle arithmetic/logic ops and iterative
// one-bit-per-cycle shifts, with valid/ready handshakes on both sides.
module seq_alu_exec #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [3:0]       op, op_d;
    logic [WIDTH-1:0] acc, acc_d;
    logic [SHW-1:0]   cnt, cnt_d;
    logic [WIDTH-1:0] result_d;
    logic             zero_d;
    logic [SHW-1:0]   shamt;
    logic             is_shift;

    // Single-cycle result; shifts only reach here with a zero amount.
    function automatic logic [WIDTH-1:0] alu_comb(input logic [3:0] code,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] r;
        r = '0;
        case (code)
            OP_ADD:  r = x + y;
            OP_SUB:  r = x - y;
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            OP_XOR:  r = x ^ y;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_SLTU: r = {{(WIDTH-1){1'b0}}, (x < y)};
            OP_SLL, OP_SRL, OP_SRA: r = x;
            default: r = '0;
        endcase
        return r;
    endfunction

    // One bit position of the iterative shifter.
    function automatic logic [WIDTH-1:0] shift_one(input logic [3:0] code,
                                                   input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        case (code)
            OP_SLL:  r = {x[WIDTH-2:0], 1'b0};
            OP_SRA:  r = {x[WIDTH-1], x[WIDTH-1:1]};
            default: r = {1'b0, x[WIDTH-1:1]};
        endcase
        return r;
    endfunction

    assign shamt    = b[SHW-1:0];
    assign is_shift = (ALUControl == OP_SLL) || (ALUControl == OP_SRL) ||
                      (ALUControl == OP_SRA);

    always_comb begin
        state_d  = state;
        op_d     = op;
        acc_d    = acc;
        cnt_d    = cnt;
        result_d = result;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    op_d = ALUControl;
                    if (is_shift && (shamt != '0)) begin
                        acc_d   = a;
                        cnt_d   = shamt;
                        state_d = SHIFT;
                    end else begin
                        result_d = alu_comb(ALUControl, a, b);
                        state_d  = DONE;
                    end
                end
            end
            SHIFT: begin
                acc_d = shift_one(op, acc);
                cnt_d = cnt - SHW'(1);
                if (cnt == SHW'(1)) begin
                    result_d = acc_d;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        zero_d = (result_d == '0);
    end

    // Handshake/status flags are registered from the next state so they track state exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            op        <= '0;
            acc       <= '0;
            cnt       <= '0;
            result    <= '0;
            zero      <= 1'b1;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            op        <= op_d;
            acc       <= acc_d;
            cnt       <= cnt_d;
            result    <= result_d;
            zero      <= zero_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            busy      <= (state_d == SHIFT);
        end
    end

endmodule

// File: tb/tb_seq_alu_exec.sv
// Randomized and directed bench for seq_alu_exec against an arithmetic reference model.
module tb_seq_alu_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_control;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    seq_alu_exec #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (alu_control),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] x,
                                          input logic [31:0] y);
        int sh;
        sh = int'(y % 32);
        case (op)
            4'd0:    return x + y;
            4'd1:    return x - y;
            4'd2:    return x & y;
            4'd3:    return x | y;
            4'd6:    return x ^ y;
            4'd5:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd10:   return (x < y) ? 32'd1 : 32'd0;
            4'd7:    return x << sh;
            4'd8:    return x >> sh;
            4'd9:    return $unsigned($signed(x) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    function automatic int exp_edges(input logic [3:0] op, input logic [31:0] y);
        if ((op == 4'd7 || op == 4'd8 || op == 4'd9) && (y % 32) != 0)
            return int'(y % 32);
        return 0;
    endfunction

    // Issue one op (caller is mid-cycle with the unit idle), check latency,
    // busy, result, zero, stall behaviour and return to idle.
    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] x,
                         input logic [31:0] y, input int stall);
        logic [31:0] exp_r;
        int          want;
        int          edges;
        exp_r = model(op, x, y);
        want  = exp_edges(op, y);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid    = 1'b1;
        alu_control = op;
        a           = x;
        b           = y;
        out_ready   = (stall == 0);
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        alu_control = 4'($urandom);
        a           = $urandom;
        b           = $urandom;
        edges = 0;
        while (!out_valid && edges < 100) begin
            if (busy !== 1'b1) begin
                check_eq({tag, "_busy"}, 32'(busy), 32'd1);
            end
            @(posedge clk);
            #1;
            edges++;
        end
        check_eq({tag, "_latency"}, 32'(edges), 32'(want));
        check_eq({tag, "_result"}, result, exp_r);
        check_eq({tag, "_zero"}, 32'(zero), 32'(exp_r == 32'd0));
        for (int k = 0; k < stall; k++) begin
            in_valid    = 1'b1;
            alu_control = 4'd0;
            a           = $urandom;
            b           = $urandom;
            @(posedge clk);
            #1;
            check_eq({tag, "_stall_result"}, result, exp_r);
            check_eq({tag, "_stall_flags"}, {29'd0, in_ready, out_valid, busy}, 32'b010);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_eq({tag, "_idle_flags"}, {29'd0, in_ready, out_valid, busy}, 32'b100);
        check_eq({tag, "_held"}, result, exp_r);
    endtask

    initial begin
        int seen;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        reset       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        alu_control = 4'd0;
        a           = 32'd0;
        b           = 32'd0;
        #12;
        check_eq("reset_state", {27'd0, in_ready, out_valid, zero, busy, 1'b0}, 32'b10100);
        check_eq("reset_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        do_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1, 0);
        do_op("sub_eq", 4'd1, 32'd5, 32'd5, 0);
        do_op("slt", 4'd5, 32'hFFFF_FFFF, 32'd1, 0);
        do_op("sltu", 4'd10, 32'hFFFF_FFFF, 32'd1, 0);
        do_op("sll31", 4'd7, 32'd1, 32'h1F, 0);
        do_op("sra4", 4'd9, 32'h8000_0000, 32'd4, 0);
        do_op("srl4", 4'd8, 32'h8000_0000, 32'd4, 0);
        do_op("srl0", 4'd8, 32'h1234, 32'h20, 0);
        do_op("sll_hi", 4'd7, 32'h0000_0003, 32'hFFFF_FFE1, 0);
        do_op("xor_bp", 4'd6, 32'hF0F0, 32'h0FF0, 6);
        do_op("ill4", 4'd4, 32'hFFFF, 32'hFFFF, 0);
        do_op("ill15", 4'd15, 32'hFFFF, 32'hFFFF, 0);

        // Reset in the middle of a long shift discards it.
        in_valid    = 1'b1;
        alu_control = 4'd7;
        a           = 32'd1;
        b           = 32'd20;
        out_ready   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_eq("rst_mid_flags", {28'd0, in_ready, out_valid, zero, busy}, 32'b1010);
        check_eq("rst_mid_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check_eq("rst_no_result", 32'(seen), 32'd0);

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom);
            ra  = $urandom;
            rb  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 3) == 0) ra = rb;
            do_op($sformatf("rand%0d", i), rop, ra, rb, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_alu_exec.md
Name: seq_alu_exec

Overview:
- Multi-cycle execution unit that consumes the 4-bit ALUControl code produced by the ALU decoder. It computes the selected operation on two operands.
- Sits in the execute stage of the multi-cycle core variant, between operand muxes and the result/writeback register.
- Arithmetic and logic ops complete in one cycle. Shifts run iteratively, one bit position per cycle, to save area.
- Valid/ready handshakes on both input and output.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- in_valid  input  1  operation request valid
- in_ready  output  1  unit can accept a request
- ALUControl  input  4  operation code, sampled on input handshake
- a  input  WIDTH  operand A, sampled on input handshake
- b  input  WIDTH  operand B, sampled on input handshake; b[SHW-1:0] is the shift amount
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  WIDTH  registered result
- zero  output  1  result == 0, registered with result
- busy  output  1  high in SHIFT state

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, in_ready=1, out_valid=0, result=0, zero=1, busy=0, shift counter=0. Takes effect immediately, including mid-shift or while holding a result; the in-flight op is discarded.
- States: IDLE, SHIFT, DONE. in_ready = (state==IDLE). out_valid = (state==DONE). busy = (state==SHIFT).
- Input handshake: in_valid & in_ready at a rising edge. ALUControl, a and b are captured at that edge only; later changes to them are ignored.
- Encoding:
  - 0000 add: a+b, mod 2^WIDTH.
  - 0001 sub: a-b, mod 2^WIDTH.
  - 0010 and.
  - 0011 or.
  - 0110 xor.
  - 0101 slt: signed a<b; result is zero-extended 0/1.
  - 1010 sltu: unsigned a<b; result is zero-extended 0/1.
  - 0111 sll.
  - 1000 srl.
  - 1001 sra.
  - All other codes (0100, 1011-1111): result=0, 1-cycle path.
- Non-shift ops, and shifts with shamt==0: IDLE->DONE at the handshake edge, with result loaded. Latency 1: out_valid is high in the cycle after acceptance. A shift with shamt==0 returns a unchanged.
- Shift with shamt=n>0:
  - At the handshake edge: IDLE->SHIFT, accumulator<=a, count<=n.
  - Each SHIFT edge: accumulator shifts by 1 (sll inserts 0 at LSB; srl inserts 0 at MSB; sra replicates MSB), and count decrements.
  - On the edge where count goes 1->0: state->DONE, result<=shifted value.
  - out_valid rises n edges after acceptance. Maximum latency is WIDTH-1 cycles.
- Only b[SHW-1:0] is used as the shift amount; upper bits of b are ignored for shifts.
- zero is updated in the same edge as result and reflects the new result.
- DONE: result and zero are held stable while out_valid=1 and out_ready=0. DONE->IDLE on an edge with out_ready=1.
- No same-cycle handoff: in_ready is low in DONE, so the earliest next acceptance is the cycle after the output handshake. Throughput is at most one op per 2 cycles.
- in_valid asserted during SHIFT or DONE: no effect. The requester must hold the request until in_ready.
- out_ready asserted while not in DONE: no effect.
- result is held between operations; it changes only on a DONE-entry edge or on reset.

Test Plan:
- Reset mid-shift: start sll a=1, b=20, pull reset low after 5 cycles -> immediately out_valid=0, in_ready=1, result=0, zero=1. No result emerges after reset releases.
- add/sub/slt/sltu, out_ready=1:
  - add a=0x7FFFFFFF, b=1 -> result=0x80000000, out_valid 1 cycle after accept.
  - sub a=5, b=5 -> result=0, zero=1.
  - slt a=0xFFFFFFFF, b=1 -> 1.
  - sltu with the same operands -> 0.
- Iterative shifts:
  - sll a=0x1, b=0x1F -> result=0x80000000, out_valid exactly 31 cycles after accept, busy high for those cycles.
  - sra a=0x80000000, b=4 -> 0xF8000000 after 4 cycles.
  - srl with the same operands -> 0x08000000.
- Shift amount edge cases: srl a=0x1234, b=0x20 (shamt field 0) -> result=0x1234 with 1-cycle latency. sll b=0xFFFFFFE1 -> shift by 1.
- Output backpressure: xor a=0xF0F0, b=0x0FF0, out_ready=0 for 6 cycles -> result=0xFF00 held stable, in_ready=0 throughout. A new in_valid during the stall is ignored. Acceptance resumes the cycle after out_ready=1.
- Illegal codes: ALUControl=0100 and 1111 with a=b=0xFFFF -> result=0, zero=1, 1-cycle latency. Random back-to-back ops checked against a reference model.
